// File: rtl/dmod_serializer.sv
// dmod_serializer: buffers packer symbols in a FIFO and shifts each out MSB-first
// on a single serial line, with a per-symbol start marker and sticky overflow.
// Optional feature macro: DMOD_SER_PARITY_EN appends one even-parity bit per frame.
module dmod_serializer #(
  parameter int SYM_W      = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int BIT_DIV    = 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [SYM_W-1:0]                  dmod,
  input  logic                              mod_en,
  output logic                              ser_out,
  output logic                              ser_valid,
  output logic                              sym_start,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt,
  output logic                              overflow,
  output logic                              idle
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
`ifdef DMOD_SER_PARITY_EN
  localparam int FRAME_BITS = SYM_W + 1;
`else
  localparam int FRAME_BITS = SYM_W;
`endif
  localparam int BIT_W = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYM_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [SYM_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             out_q, out_d, valid_q, valid_d, start_q, start_d;
  logic             ovf_q, ovf_d, idle_q, idle_d;
`ifdef DMOD_SER_PARITY_EN
  logic             par_q, par_d;
`endif
  logic [SYM_W-1:0] head;
  logic             push, pop, load;

  assign head = mem[rd_ptr_q];
  // Full check uses the registered count, so a same-edge pop never rescues a write.
  assign push = mod_en && (cnt_q != FULL_CNT);

  // Symbol storage; flushing on reset is done by clearing the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= dmod;
  end

  // Next-state logic for the FIFO bookkeeping, frame sequencer and registered outputs.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = div_q;
    out_d   = out_q;
    valid_d = valid_q;
    start_d = start_q;
`ifdef DMOD_SER_PARITY_EN
    par_d   = par_q;
`endif
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) load = 1'b1;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            if (cnt_q != '0) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              out_d   = 1'b0;
              valid_d = 1'b0;
              start_d = 1'b0;
              bit_d   = '0;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {shift_q[SYM_W-2:0], 1'b0};
            start_d = 1'b0;
`ifdef DMOD_SER_PARITY_EN
            out_d   = (bit_q == BIT_W'(SYM_W - 1)) ? par_q : shift_d[SYM_W-1];
`else
            out_d   = shift_d[SYM_W-1];
`endif
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = SHIFT;
      shift_d = head;
      bit_d   = '0;
      div_d   = '0;
      out_d   = head[SYM_W-1];
      valid_d = 1'b1;
      start_d = 1'b1;
`ifdef DMOD_SER_PARITY_EN
      par_d   = ^head;
`endif
    end
    pop      = load;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    ovf_d  = ovf_q | (mod_en && (cnt_q == FULL_CNT));
    idle_d = (state_d == IDLE) && (cnt_d == '0);
  end

  // Single state register; reset aborts any frame and flushes the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      out_q    <= 1'b0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      ovf_q    <= 1'b0;
      idle_q   <= 1'b1;
`ifdef DMOD_SER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
      ovf_q    <= ovf_d;
      idle_q   <= idle_d;
`ifdef DMOD_SER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign ser_out   = out_q;
  assign ser_valid = valid_q;
  assign sym_start = start_q;
  assign fifo_cnt  = cnt_q;
  assign overflow  = ovf_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_dmod_serializer.sv
// Directed testbench for dmod_serializer: one instance at BIT_DIV=1 and one at BIT_DIV=4.
module tb_dmod_serializer;

  localparam int SYM_W = 5;
`ifdef DMOD_SER_PARITY_EN
  localparam int FL = SYM_W + 1;
`else
  localparam int FL = SYM_W;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] dmod1 = '0, dmod4 = '0;
  logic       modEn1 = 1'b0, modEn4 = 1'b0;
  logic       serOut1, serValid1, symStart1, overflow1, idle1;
  logic       serOut4, serValid4, symStart4, overflow4, idle4;
  logic [3:0] fifoCnt1, fifoCnt4;
  int         nCompared = 0;
  int         nMismatched = 0;

  dmod_serializer #(.SYM_W(5), .FIFO_DEPTH(8), .BIT_DIV(1)) dut (
    .clk(clk), .reset_n(reset_n), .dmod(dmod1), .mod_en(modEn1),
    .ser_out(serOut1), .ser_valid(serValid1), .sym_start(symStart1),
    .fifo_cnt(fifoCnt1), .overflow(overflow1), .idle(idle1));

  dmod_serializer #(.SYM_W(5), .FIFO_DEPTH(8), .BIT_DIV(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .dmod(dmod4), .mod_en(modEn4),
    .ser_out(serOut4), .ser_valid(serValid4), .sym_start(symStart4),
    .fifo_cnt(fifoCnt4), .overflow(overflow4), .idle(idle4));

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Expected serial bit idx of a frame carrying symbol s (idx SYM_W is the parity bit).
  function automatic logic expBit(input logic [4:0] s, input int idx);
    if (idx < SYM_W) return s[SYM_W-1-idx];
    return ^s;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    nCompared += 6;
    if (serOut1 !== 1'b0)    begin nMismatched++; $display("[TB] FAIL rst_ser_out: got %b want 0", serOut1); end
    if (serValid1 !== 1'b0)  begin nMismatched++; $display("[TB] FAIL rst_ser_valid: got %b want 0", serValid1); end
    if (symStart1 !== 1'b0)  begin nMismatched++; $display("[TB] FAIL rst_sym_start: got %b want 0", symStart1); end
    if (fifoCnt1 !== 4'd0)   begin nMismatched++; $display("[TB] FAIL rst_fifo_cnt: got %0d want 0", fifoCnt1); end
    if (overflow4 !== 1'b0)  begin nMismatched++; $display("[TB] FAIL rst_overflow: got %b want 0", overflow4); end
    if (idle4 !== 1'b1)      begin nMismatched++; $display("[TB] FAIL rst_idle: got %b want 1", idle4); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    nCompared += 2;
    if (idle1 !== 1'b1)      begin nMismatched++; $display("[TB] FAIL post_rst_idle: got %b want 1", idle1); end
    if (serValid1 !== 1'b0)  begin nMismatched++; $display("[TB] FAIL post_rst_valid: got %b want 0", serValid1); end
  endtask

  task automatic test_single();
    logic [4:0] syms [2];
    syms[0] = 5'b10110;
    syms[1] = 5'b10111;
    for (int s = 0; s < 2; s++) begin
      dmod1 = syms[s];
      modEn1 = 1'b1;
      @(negedge clk);
      modEn1 = 1'b0;
      nCompared += 3;
      if (fifoCnt1 !== 4'd1)  begin nMismatched++; $display("[TB] FAIL single_cnt_after_write: got %0d want 1", fifoCnt1); end
      if (idle1 !== 1'b0)     begin nMismatched++; $display("[TB] FAIL single_idle_after_write: got %b want 0", idle1); end
      if (serValid1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_valid_latency: got %b want 0", serValid1); end
      @(negedge clk);
      for (int b = 0; b < FL; b++) begin
        nCompared += 3;
        if (serValid1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_valid bit%0d: got %b want 1", b, serValid1); end
        if (serOut1 !== expBit(syms[s], b)) begin nMismatched++; $display("[TB] FAIL single_bit%0d: got %b want %b", b, serOut1, expBit(syms[s], b)); end
        if (symStart1 !== (b == 0)) begin nMismatched++; $display("[TB] FAIL single_start bit%0d: got %b want %b", b, symStart1, (b == 0)); end
        @(negedge clk);
      end
      nCompared += 3;
      if (serValid1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_valid_end: got %b want 0", serValid1); end
      if (serOut1 !== 1'b0)   begin nMismatched++; $display("[TB] FAIL single_out_end: got %b want 0", serOut1); end
      if (idle1 !== 1'b1)     begin nMismatched++; $display("[TB] FAIL single_idle_end: got %b want 1", idle1); end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] syms [2];
    syms[0] = 5'h1F;
    syms[1] = 5'h00;
    dmod1 = syms[0];
    modEn1 = 1'b1;
    @(negedge clk);
    dmod1 = syms[1];
    @(negedge clk);
    modEn1 = 1'b0;
    for (int c = 0; c < 2 * FL; c++) begin
      nCompared += 3;
      if (serValid1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_valid c%0d: got %b want 1", c, serValid1); end
      if (serOut1 !== expBit(syms[c / FL], c % FL)) begin nMismatched++; $display("[TB] FAIL b2b_bit c%0d: got %b want %b", c, serOut1, expBit(syms[c / FL], c % FL)); end
      if (symStart1 !== ((c % FL) == 0)) begin nMismatched++; $display("[TB] FAIL b2b_start c%0d: got %b want %b", c, symStart1, ((c % FL) == 0)); end
      @(negedge clk);
    end
    nCompared += 2;
    if (serValid1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_valid_end: got %b want 0", serValid1); end
    if (idle1 !== 1'b1)     begin nMismatched++; $display("[TB] FAIL b2b_idle_end: got %b want 1", idle1); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overflow();
    fork
      begin
        for (int s = 1; s <= 10; s++) begin
          dmod4 = 5'(s);
          modEn4 = 1'b1;
          @(negedge clk);
          if (s == 9) begin
            nCompared += 2;
            if (fifoCnt4 !== 4'd8)   begin nMismatched++; $display("[TB] FAIL ovf_cnt_full: got %0d want 8", fifoCnt4); end
            if (overflow4 !== 1'b0)  begin nMismatched++; $display("[TB] FAIL ovf_early: got %b want 0", overflow4); end
          end
          if (s == 10) begin
            nCompared += 2;
            if (fifoCnt4 !== 4'd8)   begin nMismatched++; $display("[TB] FAIL ovf_cnt_after_drop: got %0d want 8", fifoCnt4); end
            if (overflow4 !== 1'b1)  begin nMismatched++; $display("[TB] FAIL ovf_set: got %b want 1", overflow4); end
          end
        end
        modEn4 = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        for (int c = 0; c < 9 * FL * 4; c++) begin
          nCompared += 3;
          if (serValid4 !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_valid c%0d: got %b want 1", c, serValid4); end
          if (serOut4 !== expBit(5'(c / (FL * 4) + 1), (c % (FL * 4)) / 4)) begin
            nMismatched++; $display("[TB] FAIL ovf_bit c%0d: got %b want %b", c, serOut4, expBit(5'(c / (FL * 4) + 1), (c % (FL * 4)) / 4));
          end
          if (symStart4 !== ((c % (FL * 4)) < 4)) begin nMismatched++; $display("[TB] FAIL ovf_start c%0d: got %b want %b", c, symStart4, ((c % (FL * 4)) < 4)); end
          @(negedge clk);
        end
      end
    join
    nCompared += 4;
    if (serValid4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_valid_end: got %b want 0", serValid4); end
    if (fifoCnt4 !== 4'd0)  begin nMismatched++; $display("[TB] FAIL ovf_cnt_end: got %0d want 0", fifoCnt4); end
    if (overflow4 !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow4); end
    if (idle4 !== 1'b1)     begin nMismatched++; $display("[TB] FAIL ovf_idle_end: got %b want 1", idle4); end
  endtask

  task automatic test_reset_mid_frame();
    for (int s = 0; s < 4; s++) begin
      dmod1 = 5'(s + 9);
      modEn1 = 1'b1;
      @(negedge clk);
    end
    modEn1 = 1'b0;
    @(negedge clk);
    nCompared += 2;
    if (fifoCnt1 !== 4'd3)  begin nMismatched++; $display("[TB] FAIL mid_cnt_before: got %0d want 3", fifoCnt1); end
    if (serOut1 !== expBit(5'd9, 3)) begin nMismatched++; $display("[TB] FAIL mid_bit3: got %b want %b", serOut1, expBit(5'd9, 3)); end
    #1 reset_n = 1'b0;
    #1;
    nCompared += 5;
    if (serValid1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_async_valid: got %b want 0", serValid1); end
    if (fifoCnt1 !== 4'd0)  begin nMismatched++; $display("[TB] FAIL mid_async_cnt: got %0d want 0", fifoCnt1); end
    if (overflow4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_async_ovf: got %b want 0", overflow4); end
    if (idle1 !== 1'b1)     begin nMismatched++; $display("[TB] FAIL mid_async_idle: got %b want 1", idle1); end
    if (symStart1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_async_start: got %b want 0", symStart1); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      nCompared += 2;
      if (serValid1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_resume_valid c%0d: got %b want 0", c, serValid1); end
      if (fifoCnt1 !== 4'd0)  begin nMismatched++; $display("[TB] FAIL mid_resume_cnt c%0d: got %0d want 0", c, fifoCnt1); end
    end
  endtask

  task automatic test_wraparound();
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          dmod1 = 5'(i * 7 + 3);
          modEn1 = 1'b1;
          @(negedge clk);
          modEn1 = 1'b0;
          for (int c = 0; c < FL; c++) begin
            nCompared += 2;
            if (fifoCnt1 > 4'd1)    begin nMismatched++; $display("[TB] FAIL wrap_cnt i%0d: got %0d want <=1", i, fifoCnt1); end
            if (overflow1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrap_ovf i%0d: got %b want 0", i, overflow1); end
            if (c < FL - 1) @(negedge clk);
          end
        end
      end
      begin
        repeat (2) @(negedge clk);
        for (int c = 0; c < 20 * FL; c++) begin
          nCompared += 2;
          if (serValid1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL wrap_valid c%0d: got %b want 1", c, serValid1); end
          if (serOut1 !== expBit(5'((c / FL) * 7 + 3), c % FL)) begin
            nMismatched++; $display("[TB] FAIL wrap_bit c%0d: got %b want %b", c, serOut1, expBit(5'((c / FL) * 7 + 3), c % FL));
          end
          @(negedge clk);
        end
      end
    join
    nCompared += 3;
    if (serValid1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrap_valid_end: got %b want 0", serValid1); end
    if (idle1 !== 1'b1)     begin nMismatched++; $display("[TB] FAIL wrap_idle_end: got %b want 1", idle1); end
    if (overflow1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrap_ovf_end: got %b want 0", overflow1); end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_wraparound();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
